// File: rtl/fifo_rd_stream_adapter_if.sv
// Read-side bundle: async FIFO read port, stream output and the transfer counter.
// The adapter drives through the master modport; the FIFO/sink side uses slave.
interface fifo_rd_stream_adapter_if #(
    parameter int FIFO_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
);
    logic                  enable;
    logic                  empty;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  r_en;
    logic                  m_valid;
    logic [FIFO_WIDTH-1:0] m_data;
    logic                  m_ready;
    logic [CNT_WIDTH-1:0]  rd_count;

    modport master (
        input  enable,
        input  empty,
        input  data_out,
        input  m_ready,
        output r_en,
        output m_valid,
        output m_data,
        output rd_count
    );

    modport slave (
        output enable,
        output empty,
        output data_out,
        output m_ready,
        input  r_en,
        input  m_valid,
        input  m_data,
        input  rd_count
    );
endinterface

// File: rtl/fifo_rd_stream_adapter.sv
// Read-clock-domain consumer of the async FIFO: issues reads, captures the
// one-cycle-late read data into a 2-entry skid buffer and streams it out.
module fifo_rd_stream_adapter #(
    parameter int FIFO_WIDTH = 32,
    parameter int BUF_DEPTH  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                      rclk,
    input  logic                      rrst_n,
    fifo_rd_stream_adapter_if.master  bus
);

    localparam logic [2:0] DEPTH3 = 3'(BUF_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STALL,
        DRAIN
    } state_t;

    state_t                state;
    logic [1:0]            occ;
    logic                  inflight;
    logic [FIFO_WIDTH-1:0] head_q;
    logic [FIFO_WIDTH-1:0] tail_q;
    logic [CNT_WIDTH-1:0]  count_q;

    logic                  pop;
    logic                  push;
    logic [2:0]            pending;
    logic                  room;
    logic                  r_en_int;
    logic [1:0]            occ_nxt;

    // Words already buffered plus the one still coming back from the FIFO,
    // minus the one leaving this cycle, must leave a free slot for a new read.
    assign pop      = (occ != 2'd0) && bus.m_ready;
    assign push     = inflight;
    assign pending  = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign room     = pending < DEPTH3;
    assign r_en_int = rrst_n && bus.enable && !bus.empty && room
                      && ((state != STALL) || pop);

    assign bus.r_en     = r_en_int;
    assign bus.m_valid  = (occ != 2'd0);
    assign bus.m_data   = head_q;
    assign bus.rd_count = count_q;

    always_comb begin
        occ_nxt = occ;
        case ({push, pop})
            2'b10:   occ_nxt = (occ == 2'd2) ? occ : occ + 2'd1;
            2'b01:   occ_nxt = occ - 2'd1;
            default: occ_nxt = occ;
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state    <= IDLE;
            occ      <= 2'd0;
            inflight <= 1'b0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
        end else begin
            inflight <= r_en_int;
            occ      <= occ_nxt;

            // head_q is always the oldest word; tail_q only holds the second one.
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        head_q <= bus.data_out;
                    end else if (occ == 2'd1) begin
                        tail_q <= bus.data_out;
                    end
                end
                2'b01: begin
                    head_q <= tail_q;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head_q <= bus.data_out;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= bus.data_out;
                    end
                end
                default: begin
                end
            endcase

            if (pop) begin
                count_q <= count_q + CNT_WIDTH'(1);
            end

            if (!bus.enable) begin
                state <= ((occ_nxt != 2'd0) || r_en_int) ? DRAIN : IDLE;
            end else begin
                state <= (occ_nxt == 2'd2) ? STALL : RUN;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Directed bench: a queue-backed FIFO model feeds the adapter, a negedge
// monitor collects r_en pulses and stream transfers for in-order checks.
module tb_fifo_rd_stream_adapter;

    logic rclk   = 1'b0;
    logic rrst_n = 1'b1;

    fifo_rd_stream_adapter_if #(.FIFO_WIDTH(32), .CNT_WIDTH(16)) bus ();
    fifo_rd_stream_adapter_if #(.FIFO_WIDTH(32), .CNT_WIDTH(4))  wif ();

    fifo_rd_stream_adapter #(.FIFO_WIDTH(32), .BUF_DEPTH(2), .CNT_WIDTH(16)) u_dut (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (bus)
    );

    fifo_rd_stream_adapter #(.FIFO_WIDTH(32), .BUF_DEPTH(2), .CNT_WIDTH(4)) u_wrap (
        .rclk   (rclk),
        .rrst_n (rrst_n),
        .bus    (wif)
    );

    initial forever #5 rclk = ~rclk;

    int          checks     = 0;
    int          failures   = 0;
    logic [31:0] fifo_q[$];
    logic [31:0] rx_q[$];
    int          ren_cnt    = 0;
    int          viol       = 0;
    int          underflow  = 0;
    logic        toggle_mode = 1'b0;
    logic        phase      = 1'b0;
    int          wrap_reads = 0;
    int          wrap_limit = 0;

    // FIFO model: data returns one cycle after r_en; empty is optionally forced
    // high on alternate cycles.
    always @(posedge rclk) begin
        if (bus.r_en) begin
            if (fifo_q.size() > 0) begin
                bus.data_out <= fifo_q.pop_front();
            end else begin
                underflow <= underflow + 1;
            end
        end
        phase     <= ~phase;
        bus.empty <= (fifo_q.size() == 0) || (toggle_mode && !phase);
    end

    always @(posedge rclk) begin
        if (wif.r_en) begin
            wif.data_out <= 32'(wrap_reads);
            wrap_reads   <= wrap_reads + 1;
        end
        wif.empty <= (wrap_reads + (wif.r_en ? 1 : 0)) >= wrap_limit;
    end

    always @(negedge rclk) begin
        if (rrst_n) begin
            if (bus.r_en) ren_cnt <= ren_cnt + 1;
            if (bus.r_en && bus.empty) viol <= viol + 1;
            if (bus.m_valid && bus.m_ready) rx_q.push_back(bus.m_data);
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rx_at(input int idx);
        return (idx < rx_q.size()) ? rx_q[idx] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        int ren_base;
        int rx_base;
        int viol_base;
        int rf, rl, rn, mf, ml, mn;
        logic hold_ok;
        logic found;
        logic saw_wrap;
        logic [3:0] prev_cnt;

        bus.enable  = 1'b0;
        bus.m_ready = 1'b0;
        wif.enable  = 1'b0;
        wif.m_ready = 1'b1;
        #2 rrst_n = 1'b0;
        repeat (3) @(posedge rclk);
        #1;
        $display("[TB] reset state");
        check_output("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check_output("rst_r_en", 32'(bus.r_en), 32'd0);
        check_output("rst_rd_count", 32'(bus.rd_count), 32'd0);
        rrst_n = 1'b1;

        // Test 1: async reset while the skid buffer is full
        $display("[TB] async reset mid-stream");
        for (int i = 0; i < 5; i++) fifo_q.push_back(32'h10 + 32'(i));
        bus.enable = 1'b1;
        @(posedge rclk); #1;
        repeat (4) @(negedge rclk);
        check_output("t1_pre_m_valid", 32'(bus.m_valid), 32'd1);
        check_output("t1_pre_r_en", 32'(bus.r_en), 32'd0);
        check_output("t1_pre_m_data", bus.m_data, 32'h10);
        #1 rrst_n = 1'b0;
        #1;
        check_output("t1_m_valid", 32'(bus.m_valid), 32'd0);
        check_output("t1_m_data", bus.m_data, 32'd0);
        check_output("t1_rd_count", 32'(bus.rd_count), 32'd0);
        check_output("t1_r_en", 32'(bus.r_en), 32'd0);
        bus.enable = 1'b0;
        fifo_q.delete();
        repeat (2) @(posedge rclk);
        #1 rrst_n = 1'b1;

        // Test 2: continuous stream of four words
        $display("[TB] streaming");
        bus.m_ready = 1'b1;
        for (int i = 0; i < 4; i++) fifo_q.push_back(32'hA0 + 32'(i));
        rx_base  = rx_q.size();
        @(posedge rclk); #1;
        bus.enable = 1'b1;
        rf = -1; rl = -1; rn = 0; mf = -1; ml = -1; mn = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge rclk);
            if (bus.r_en) begin
                if (rf < 0) rf = c;
                rl = c;
                rn++;
            end
            if (bus.m_valid) begin
                if (mf < 0) mf = c;
                ml = c;
                mn++;
            end
        end
        check_output("t2_ren_count", 32'(rn), 32'd4);
        check_output("t2_ren_contig", 32'(rl - rf + 1), 32'd4);
        check_output("t2_mv_count", 32'(mn), 32'd4);
        check_output("t2_mv_contig", 32'(ml - mf + 1), 32'd4);
        check_output("t2_start_latency", 32'((mf - rf) inside {1, 2}), 32'd1);
        check_output("t2_rx_size", 32'(rx_q.size() - rx_base), 32'd4);
        for (int i = 0; i < 4; i++) check_output("t2_order", rx_at(rx_base + i), 32'hA0 + 32'(i));
        check_output("t2_rd_count", 32'(bus.rd_count), 32'd4);

        // Test 3: backpressure, then release
        $display("[TB] backpressure");
        @(posedge rclk); #1;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 8; i++) fifo_q.push_back(32'hB0 + 32'(i));
        ren_base = ren_cnt;
        rx_base  = rx_q.size();
        hold_ok  = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge rclk);
            if (bus.m_valid && bus.m_data !== 32'hB0) hold_ok = 1'b0;
        end
        check_output("t3_ren_pulses", 32'(ren_cnt - ren_base), 32'd2);
        check_output("t3_r_en_low", 32'(bus.r_en), 32'd0);
        check_output("t3_m_valid", 32'(bus.m_valid), 32'd1);
        check_output("t3_m_data", bus.m_data, 32'hB0);
        check_output("t3_hold", 32'(hold_ok), 32'd1);
        @(posedge rclk); #1;
        bus.m_ready = 1'b1;
        repeat (20) @(negedge rclk);
        check_output("t3_ren_total", 32'(ren_cnt - ren_base), 32'd8);
        check_output("t3_rx_size", 32'(rx_q.size() - rx_base), 32'd8);
        for (int i = 0; i < 8; i++) check_output("t3_order", rx_at(rx_base + i), 32'hB0 + 32'(i));
        check_output("t3_rd_count", 32'(bus.rd_count), 32'd12);

        // Test 4: empty toggling every cycle
        $display("[TB] empty gating");
        @(posedge rclk); #1;
        toggle_mode = 1'b1;
        for (int i = 0; i < 6; i++) fifo_q.push_back(32'hC0 + 32'(i));
        ren_base  = ren_cnt;
        rx_base   = rx_q.size();
        viol_base = viol;
        repeat (30) @(negedge rclk);
        check_output("t4_ren_while_empty", 32'(viol - viol_base), 32'd0);
        check_output("t4_ren_total", 32'(ren_cnt - ren_base), 32'd6);
        check_output("t4_rx_size", 32'(rx_q.size() - rx_base), 32'd6);
        for (int i = 0; i < 6; i++) check_output("t4_order", rx_at(rx_base + i), 32'hC0 + 32'(i));
        check_output("t4_underflow", 32'(underflow), 32'd0);

        // Test 5: enable falls the cycle after a read is issued
        $display("[TB] enable drop");
        @(posedge rclk); #1;
        toggle_mode = 1'b0;
        bus.enable  = 1'b0;
        for (int i = 0; i < 3; i++) fifo_q.push_back(32'hE0 + 32'(i));
        @(posedge rclk); #1;
        ren_base = ren_cnt;
        rx_base  = rx_q.size();
        bus.enable = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 10 && !found; c++) begin
            @(negedge rclk);
            if (bus.r_en) found = 1'b1;
        end
        check_output("t5_r_en_seen", 32'(found), 32'd1);
        @(posedge rclk); #1;
        bus.enable = 1'b0;
        repeat (10) @(negedge rclk);
        check_output("t5_ren_once", 32'(ren_cnt - ren_base), 32'd1);
        check_output("t5_r_en_low", 32'(bus.r_en), 32'd0);
        check_output("t5_rx_size", 32'(rx_q.size() - rx_base), 32'd1);
        check_output("t5_inflight_word", rx_at(rx_base), 32'hE0);
        @(posedge rclk); #1;
        bus.enable = 1'b1;
        repeat (10) @(negedge rclk);
        check_output("t5_ren_resume", 32'(ren_cnt - ren_base), 32'd3);
        check_output("t5_rx_rest1", rx_at(rx_base + 1), 32'hE1);
        check_output("t5_rx_rest2", rx_at(rx_base + 2), 32'hE2);

        // Test 6: 4-bit counter wrap after 17 transfers
        $display("[TB] counter wrap");
        @(posedge rclk); #1;
        wrap_limit = 17;
        wif.enable = 1'b1;
        saw_wrap = 1'b0;
        prev_cnt = wif.rd_count;
        for (int c = 0; c < 40; c++) begin
            @(negedge rclk);
            if (prev_cnt == 4'd15 && wif.rd_count == 4'd0) saw_wrap = 1'b1;
            prev_cnt = wif.rd_count;
        end
        check_output("t6_saw_wrap", 32'(saw_wrap), 32'd1);
        check_output("t6_final_count", 32'(wif.rd_count), 32'd1);
        check_output("t6_reads", 32'(wrap_reads), 32'd17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
